// File: rtl/lcd_bus_driver_pkg.sv
// Shared types and constants for the HD44780 bus driver: FSM states, request word,
// init ROM contents and default panel timing (cycles of clk_20m).
package lcd_bus_driver_pkg;

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_INIT_LD  = 3'd1,
        S_IDLE     = 3'd2,
        S_SETUP    = 3'd3,
        S_EPULSE   = 3'd4,
        S_HOLD     = 3'd5,
        S_EXEC     = 3'd6
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] code;
    } lcd_req_t;

    localparam int INIT_LEN = 6;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    localparam int DEF_T_PWR  = 300000;
    localparam int DEF_T_AS   = 1;
    localparam int DEF_T_PW   = 6;
    localparam int DEF_T_H    = 1;
    localparam int DEF_T_EXEC = 800;
    localparam int DEF_T_CLR  = 32000;
    localparam int DEF_FDEPTH = 4;

    // 8-bit, 2-line, display on, entry increment, then clear.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h06;
            3'd5:             init_rom = CMD_CLEAR;
            default:          init_rom = 8'h00;
        endcase
    endfunction

    function automatic logic is_long_cmd(input lcd_req_t req);
        is_long_cmd = !req.rs &&
                      (req.code == CMD_CLEAR || req.code == CMD_HOME || req.code == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_bus_driver_fifo.sv
// Small request FIFO of {rs, byte} words; a push while full is accepted only if a pop
// happens in the same cycle.
module lcd_bus_driver_fifo
    import lcd_bus_driver_pkg::*;
#(
    parameter int FDEPTH = DEF_FDEPTH
) (
    input  logic     clk_20m,
    input  logic     rst,
    input  logic     push,
    input  lcd_req_t din,
    input  logic     pop,
    output lcd_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(FDEPTH);

    lcd_req_t        mem [FDEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_20m) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write-only bus driver: power-on init, clk2-strobed request capture into a
// FIFO, and E-pulse / execution-time sequencing so upstream logic never waits on the panel.
module lcd_bus_driver
    import lcd_bus_driver_pkg::*;
#(
    parameter int T_PWR  = DEF_T_PWR,
    parameter int T_AS   = DEF_T_AS,
    parameter int T_PW   = DEF_T_PW,
    parameter int T_H    = DEF_T_H,
    parameter int T_EXEC = DEF_T_EXEC,
    parameter int T_CLR  = DEF_T_CLR,
    parameter int FDEPTH = DEF_FDEPTH
) (
    input  logic       clk_20m,
    input  logic       rst,
    input  logic       clk2,
    input  logic       wr,
    input  logic       dr,
    input  logic [7:0] dbi,
    input  logic [7:0] direc,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       ready,
    output logic       busy,
    output logic       ovf
);

    localparam int CNT_W = $clog2(T_PWR + 1);

    // A state lasting N cycles is entered with N-1 and left when the counter reads 0.
    localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] AS_LD   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] PW_LD   = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] H_LD    = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] EXEC_LD = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(T_CLR - 1);
    localparam logic [2:0]       IDX_LAST = 3'(INIT_LEN - 1);

    lcd_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       idx, idx_nx;
    logic             ready_nx;
    lcd_req_t         cur_req;
    logic             ld_en;
    lcd_req_t         ld_req;

    logic             clk2_s1, clk2_s2, clk2_s3;
    logic             cap_stb;
    logic             push;
    lcd_req_t         push_req;
    logic             pop;
    lcd_req_t         fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            clk2_s1 <= 1'b0;
            clk2_s2 <= 1'b0;
            clk2_s3 <= 1'b0;
            cap_stb <= 1'b0;
        end else begin
            clk2_s1 <= clk2;
            clk2_s2 <= clk2_s1;
            clk2_s3 <= clk2_s2;
            cap_stb <= clk2_s2 && !clk2_s3;
        end
    end

    // Command request takes priority when both levels are asserted.
    assign push     = cap_stb && (dr || wr);
    assign push_req = dr ? lcd_req_t'{rs: 1'b0, code: direc} : lcd_req_t'{rs: 1'b1, code: dbi};

    lcd_bus_driver_fifo #(
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clk_20m (clk_20m),
        .rst     (rst),
        .push    (push),
        .din     (push_req),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        idx_nx   = idx;
        ready_nx = ready;
        ld_en    = 1'b0;
        ld_req   = '0;
        pop      = 1'b0;
        case (state)
            S_PWR_WAIT: begin
                if (cnt == '0) state_nx = S_INIT_LD;
            end
            S_INIT_LD: begin
                ld_en    = 1'b1;
                ld_req   = lcd_req_t'{rs: 1'b0, code: init_rom(idx)};
                state_nx = S_SETUP;
                cnt_nx   = AS_LD;
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    ld_en    = 1'b1;
                    ld_req   = fifo_dout;
                    state_nx = S_SETUP;
                    cnt_nx   = AS_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_EPULSE;
                    cnt_nx   = PW_LD;
                end
            end
            S_EPULSE: begin
                if (cnt == '0) begin
                    state_nx = S_HOLD;
                    cnt_nx   = H_LD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nx = S_EXEC;
                    cnt_nx   = is_long_cmd(cur_req) ? CLR_LD : EXEC_LD;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    if (ready) begin
                        state_nx = S_IDLE;
                    end else if (idx == IDX_LAST) begin
                        ready_nx = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = S_INIT_LD;
                    end
                end
            end
            default: state_nx = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk_20m) begin
        if (rst) begin
            state   <= S_PWR_WAIT;
            cnt     <= PWR_LD;
            idx     <= '0;
            ready   <= 1'b0;
            cur_req <= '0;
            lcd_e   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            ready <= ready_nx;
            lcd_e <= (state_nx == S_EPULSE);
            if (ld_en) cur_req <= ld_req;
            if (push && fifo_full && !pop) ovf <= 1'b1;
        end
    end

    assign lcd_rs = cur_req.rs;
    assign lcd_db = cur_req.code;
    assign lcd_rw = 1'b0;
    assign busy   = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: stimulus predicts bus writes into a queue, a negedge
// monitor pops on every E rise and checks byte, RS, E width and inter-write spacing.
module tb_lcd_bus_driver;

    localparam int T_PWR = 20, T_AS = 1, T_PW = 3, T_H = 1, T_EXEC = 8, T_CLR = 30, FDEPTH = 4;

    logic       clk_20m = 1'b0;
    logic       rst = 1'b1;
    logic       clk2 = 1'b0;
    logic       wr = 1'b0;
    logic       dr = 1'b0;
    logic [7:0] dbi = 8'h00;
    logic [7:0] direc = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e, ready, busy, ovf;
    logic [7:0] lcd_db;

    lcd_bus_driver #(
        .T_PWR (T_PWR), .T_AS (T_AS), .T_PW (T_PW), .T_H (T_H),
        .T_EXEC (T_EXEC), .T_CLR (T_CLR), .FDEPTH (FDEPTH)
    ) dut (
        .clk_20m (clk_20m), .rst (rst), .clk2 (clk2), .wr (wr), .dr (dr),
        .dbi (dbi), .direc (direc), .lcd_rs (lcd_rs), .lcd_rw (lcd_rw),
        .lcd_e (lcd_e), .lcd_db (lcd_db), .ready (ready), .busy (busy), .ovf (ovf)
    );

    always #5 clk_20m = ~clk_20m;

    typedef struct {
        logic       rs;
        logic [7:0] b;
        bit         init;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_gap = 0;
    int   init_cnt = 0;
    bit   exp_ovf = 0;
    logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit long_wait(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

    // Bus-side monitor
    bit   e_prev = 0, have_prev = 0;
    int   hi_cnt = 0, lo_cnt = 0, cyc = 0, prev_wait = 0;
    exp_t cur;
    logic prs = 0;
    logic [7:0] pdb = 0;

    always @(negedge clk_20m) begin
        if (rst) begin
            e_prev = 0; have_prev = 0; hi_cnt = 0; lo_cnt = 0; cyc = 0;
        end else begin
            cyc++;
            if (lcd_e && !e_prev) begin
                chk("setup_stable", {prs, pdb}, {lcd_rs, lcd_db});
                chk("rw_low", lcd_rw, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {lcd_rs, lcd_db}, 9'h1ff);
                    cur = '{lcd_rs, lcd_db, 0};
                end else begin
                    cur = sb.pop_front();
                    chk("pulse_rs", lcd_rs, cur.rs);
                    chk("pulse_db", lcd_db, cur.b);
                    chk("ready_at_pulse", ready, !cur.init);
                end
                if (have_prev) chk_range("gap_min", lo_cnt, T_H + prev_wait + T_AS, 100000);
                else           chk_range("power_on_wait", cyc, T_PWR, 100000);
                last_gap = lo_cnt;
                hi_cnt = 1;
            end else if (lcd_e) begin
                hi_cnt++;
                chk("db_stable_high", {lcd_rs, lcd_db}, {cur.rs, cur.b});
            end else if (e_prev) begin
                chk("e_width", hi_cnt, T_PW);
                chk("db_hold", {lcd_rs, lcd_db}, {cur.rs, cur.b});
                have_prev = 1;
                prev_wait = long_wait(cur.rs, cur.b) ? T_CLR : T_EXEC;
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            e_prev = lcd_e; prs = lcd_rs; pdb = lcd_db;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_20m);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        step(1);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ovf", ovf, 0);
        step(2);
        foreach (init_bytes[i]) sb.push_back('{1'b0, init_bytes[i], 1'b1});
        init_cnt = 0;
        exp_ovf = 0;
        rst = 1'b0;
    endtask

    // One upstream step: present levels, raise clk2, hold until well after capture.
    task automatic issue(input bit w, input bit d, input logic [7:0] db, input logic [7:0] dc,
                         input bit init_phase);
        exp_t e;
        bit   p;
        wr = w; dr = d; dbi = db; direc = dc;
        p = w || d;
        e = d ? exp_t'{1'b0, dc, 1'b0} : exp_t'{1'b1, db, 1'b0};
        if (p) begin
            if (!init_phase) sb.push_back(e);
            else if (init_cnt < FDEPTH) begin
                sb.push_back(e);
                init_cnt++;
            end else exp_ovf = 1;
        end
        step(1);
        clk2 = 1'b1;
        step(4);
        clk2 = 1'b0;
        step(2);
        wr = 1'b0; dr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
            step(1);
        end
        chk(name, ok, 1);
    endtask

    initial begin
        // Power-on init with no traffic
        do_reset();
        wait_idle("init_done");
        chk("ready_after_init", ready, 1);
        chk("ovf_after_init", ovf, 0);

        issue(1, 0, 8'h55, 8'h00, 0);
        wait_idle("data_write");

        issue(0, 1, 8'h00, 8'h01, 0);
        issue(1, 0, 8'h41, 8'h00, 0);
        wait_idle("clear_then_data");
        issue(0, 1, 8'h00, 8'h81, 0);
        issue(1, 0, 8'h42, 8'h00, 0);
        wait_idle("short_cmd_then_data");
        chk_range("short_cmd_gap", last_gap, T_H + T_EXEC + T_AS, T_H + T_EXEC + T_AS + 2);

        issue(1, 1, 8'h55, 8'h94, 0);
        wait_idle("dr_priority");

        // Random bursts that never exceed the FIFO
        for (int b = 0; b < 12; b++) begin
            int n = $urandom_range(1, FDEPTH);
            for (int k = 0; k < n; k++) begin
                logic [7:0] rdc;
                rdc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
                issue(1'($urandom), 1'($urandom), 8'($urandom), rdc, 0);
            end
            wait_idle("random_burst");
        end
        chk("ovf_no_drop", ovf, 0);

        // Overflow while init holds the FIFO
        do_reset();
        for (int k = 0; k < 6; k++) issue(1, 0, 8'h30 + 8'(k), 8'h00, 1);
        step(2);
        chk("ovf_set", ovf, exp_ovf);
        wait_idle("overflow_drain");
        chk("ready_after_ovf_init", ready, 1);
        chk("ovf_sticky", ovf, 1);

        // Reset in the middle of an E pulse
        begin
            bit seen = 0;
            wr = 1'b1; dbi = 8'h77;
            sb.push_back('{1'b1, 8'h77, 1'b0});
            step(1); clk2 = 1'b1;
            for (int i = 0; i < 40; i++) begin
                if (lcd_e) begin
                    seen = 1;
                    break;
                end
                step(1);
            end
            chk("e_rise_before_reset", seen, 1);
            clk2 = 1'b0; wr = 1'b0;
        end
        do_reset();
        wait_idle("reinit_after_reset");
        chk("ready_after_reinit", ready, 1);
        issue(1, 0, 8'h5A, 8'h00, 0);
        wait_idle("post_reset_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
